alu_config_writer: RTL and testbench

Configuration master for a bank of SimpleALU-style opcode config registers (D/Q/EN per target, shared data bus).
- Accepts (target, data) write commands from a host over a valid/ready interface.
- Buffers commands in a small FIFO.
- Issues each write as a one-cycle one-hot enable pulse.
- Optionally reads back the target's Q to verify the write landed.

---
 rtl/alu_config_writer.sv | 160 ++++++++++++++++
 tb/tb_alu_config_writer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_config_writer.sv
// Configuration master for a bank of opcode config registers: FIFO-buffered
// host writes issued as one-hot enable pulses. Define CFG_VERIFY_EN to add readback checking.
module alu_config_writer #(
  parameter int NUM_TARGETS = 4,
  parameter int DATA_W      = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int TGT_W       = 2
) (
  input  logic                          CLK,
  input  logic                          RESETN,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [TGT_W-1:0]              cmd_target,
  input  logic [DATA_W-1:0]             cmd_data,
  output logic [DATA_W-1:0]             cfg_data,
  output logic [NUM_TARGETS-1:0]        cfg_en,
  input  logic [NUM_TARGETS*DATA_W-1:0] cfg_readback,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [TGT_W-1:0]              err_target,
  input  logic                          err_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [TGT_W-1:0]  tgt;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CHECK} state_t;

  cmd_t             r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;

  state_t            r_state, w_state_nxt;
  logic [TGT_W-1:0]  r_tgt;
  logic [DATA_W-1:0] r_data;
  logic              r_done;
  logic              r_err;
  logic [TGT_W-1:0]  r_err_tgt;

  logic             w_push, w_pop, w_in_range;
  logic             w_done_set, w_err_set;
  logic [TGT_W-1:0] w_err_tgt;
  cmd_t             w_cmd_in, w_head;

  assign cmd_ready  = (r_count != CNT_W'(FIFO_DEPTH));
  assign w_push     = cmd_valid && cmd_ready;
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_cmd_in   = {cmd_target, cmd_data};
  assign w_head     = r_mem[r_rptr];
  assign w_in_range = (32'(w_head.tgt) < NUM_TARGETS);

  // Storage carries no reset; occupancy and pointers alone define validity.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= w_cmd_in;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pop && w_in_range) w_state_nxt = S_WRITE;
`ifdef CFG_VERIFY_EN
      S_WRITE: w_state_nxt = S_CHECK;
`else
      S_WRITE: w_state_nxt = S_IDLE;
`endif
      S_CHECK: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= S_IDLE;
      r_tgt   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop && w_in_range) begin
        r_tgt  <= w_head.tgt;
        r_data <= w_head.data;
      end
    end
  end

`ifdef CFG_VERIFY_EN
  logic [DATA_W-1:0] w_rb;
  logic              w_match;

  always_comb begin
    w_rb = '0;
    for (int i = 0; i < NUM_TARGETS; i++)
      if (32'(r_tgt) == i) w_rb = cfg_readback[i*DATA_W +: DATA_W];
  end

  assign w_match    = (w_rb == r_data);
  assign w_done_set = (r_state == S_CHECK) && w_match;
  assign w_err_set  = (w_pop && !w_in_range) || ((r_state == S_CHECK) && !w_match);
`else
  logic w_unused_rb;
  assign w_unused_rb = ^cfg_readback;
  assign w_done_set  = (r_state == S_WRITE);
  assign w_err_set   = w_pop && !w_in_range;
`endif

  // A pop only happens in IDLE, so a range error and a check error never coincide.
  assign w_err_tgt = (r_state == S_IDLE) ? w_head.tgt : r_tgt;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_err_tgt <= '0;
    end else begin
      r_done <= w_done_set;
      if (w_err_set) begin
        r_err     <= 1'b1;
        r_err_tgt <= w_err_tgt;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  // Enable and bus are decoded from state so an async reset kills a pulse at once.
  always_comb begin
    cfg_en   = '0;
    cfg_data = '0;
    for (int i = 0; i < NUM_TARGETS; i++)
      cfg_en[i] = (r_state == S_WRITE) && (32'(r_tgt) == i);
    if (r_state == S_WRITE) cfg_data = r_data;
  end

  assign busy       = (r_count != '0) || (r_state != S_IDLE);
  assign done       = r_done;
  assign err        = r_err;
  assign err_target = r_err_tgt;

endmodule

// File: tb/tb_alu_config_writer.sv
// Scoreboard bench for alu_config_writer; a monitor pops expected writes,
// done pulses and errors as the DUT presents them. Adapts to CFG_VERIFY_EN.
module tb_alu_config_writer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RESETN;
  int   cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // main DUT: 4 targets
  logic       c0_valid, c0_ready, c0_busy, c0_done, c0_err, c0_errclr;
  logic [1:0] c0_tgt, c0_data, c0_cfg_data, c0_errt;
  logic [3:0] c0_en, rb_kill;
  logic [7:0] c0_rb;
  logic [1:0] q0 [4] = '{default: 2'b00};

  alu_config_writer #(.NUM_TARGETS(4), .DATA_W(2), .FIFO_DEPTH(4), .TGT_W(2)) u_dut0 (
    .CLK(CLK), .RESETN(RESETN), .cmd_valid(c0_valid), .cmd_ready(c0_ready),
    .cmd_target(c0_tgt), .cmd_data(c0_data), .cfg_data(c0_cfg_data), .cfg_en(c0_en),
    .cfg_readback(c0_rb), .busy(c0_busy), .done(c0_done), .err(c0_err),
    .err_target(c0_errt), .err_clr(c0_errclr));

  always @(posedge CLK)
    for (int i = 0; i < 4; i++) if (c0_en[i]) q0[i] <= c0_cfg_data;

  always_comb begin
    c0_rb = '0;
    for (int i = 0; i < 4; i++) c0_rb[i*2 +: 2] = rb_kill[i] ? 2'b00 : q0[i];
  end

  // second DUT: 3 targets, for the out-of-range case
  logic       c1_valid, c1_ready, c1_busy, c1_done, c1_err, c1_errclr;
  logic [1:0] c1_tgt, c1_data, c1_cfg_data, c1_errt;
  logic [2:0] c1_en;
  logic [5:0] c1_rb;
  logic [1:0] q1 [3] = '{default: 2'b00};

  alu_config_writer #(.NUM_TARGETS(3), .DATA_W(2), .FIFO_DEPTH(4), .TGT_W(2)) u_dut1 (
    .CLK(CLK), .RESETN(RESETN), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_target(c1_tgt), .cmd_data(c1_data), .cfg_data(c1_cfg_data), .cfg_en(c1_en),
    .cfg_readback(c1_rb), .busy(c1_busy), .done(c1_done), .err(c1_err),
    .err_target(c1_errt), .err_clr(c1_errclr));

  always @(posedge CLK)
    for (int i = 0; i < 3; i++) if (c1_en[i]) q1[i] <= c1_cfg_data;

  always_comb begin
    c1_rb = '0;
    for (int i = 0; i < 3; i++) c1_rb[i*2 +: 2] = q1[i];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0] en;
    logic [1:0] data;
  } wr_t;

  wr_t exp_wr   [$];
  int  exp_done [$];
  int  exp_err  [$];

  function automatic int onehot_idx(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  int   last_tgt = -1;
  logic prev_err = 1'b0;

  always @(negedge CLK) begin : monitor
    wr_t w;
    if (c0_en != 4'b0) begin
      check("en_onehot", 32'($onehot(c0_en)), 32'd1);
      if (exp_wr.size() == 0) check("unexpected_write", 32'(c0_en), 32'd0);
      else begin
        w = exp_wr.pop_front();
        check("write_en", 32'(c0_en), 32'(w.en));
        check("write_data", 32'(c0_cfg_data), 32'(w.data));
      end
      last_tgt <= onehot_idx(c0_en);
    end
    if (c0_done) begin
      if (exp_done.size() == 0) check("unexpected_done", 32'(c0_done), 32'd0);
      else check("done_target", 32'(last_tgt), 32'(exp_done.pop_front()));
    end
    if (c0_err && !prev_err) begin
      if (exp_err.size() == 0) check("unexpected_err", 32'(c0_err), 32'd0);
      else check("err_target", 32'(c0_errt), 32'(exp_err.pop_front()));
    end
    prev_err <= c0_err;
  end

  task automatic edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send0(input logic [1:0] t, input logic [1:0] d, output int acc);
    int w = 0;
    @(negedge CLK);
    c0_valid = 1'b1; c0_tgt = t; c0_data = d;
    while (!c0_ready && w < 50) begin @(negedge CLK); w++; end
    if (!c0_ready) check("send0_timeout", 32'(c0_ready), 32'd1);
    acc = cyc + 1;
    @(posedge CLK); #1;
    c0_valid = 1'b0;
  endtask

  task automatic send1(input logic [1:0] t, input logic [1:0] d);
    int w = 0;
    @(negedge CLK);
    c1_valid = 1'b1; c1_tgt = t; c1_data = d;
    while (!c1_ready && w < 50) begin @(negedge CLK); w++; end
    if (!c1_ready) check("send1_timeout", 32'(c1_ready), 32'd1);
    @(posedge CLK); #1;
    c1_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (c0_busy && k < budget) begin edges(1); k++; end
    check("idle_timeout", 32'(c0_busy), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!c0_done && k < budget) begin edges(1); k++; end
    check("done_timeout", 32'(c0_done), 32'd1);
  endtask

  logic [1:0] fill_tgt  [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
  logic [1:0] fill_data [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3};
`ifdef CFG_VERIFY_EN
  int fill_off [8] = '{0, 1, 2, 3, 4, 5, 8, 11};
`else
  int fill_off [8] = '{0, 1, 2, 3, 4, 5, 6, 8};
`endif

  initial begin
    int   acc;
    int   accs [8];
    logic saw_en, saw_done;
    logic [2:0] en_seen;
    wr_t  w;

    RESETN = 1'b0; rb_kill = 4'b0;
    c0_valid = 1'b0; c0_tgt = '0; c0_data = '0; c0_errclr = 1'b0;
    c1_valid = 1'b0; c1_tgt = '0; c1_data = '0; c1_errclr = 1'b0;

    // reset state
    #12;
    check("rst_cfg_en", 32'(c0_en), 32'd0);
    check("rst_cfg_data", 32'(c0_cfg_data), 32'd0);
    check("rst_done", 32'(c0_done), 32'd0);
    check("rst_err", 32'(c0_err), 32'd0);
    check("rst_err_target", 32'(c0_errt), 32'd0);
    check("rst_busy", 32'(c0_busy), 32'd0);
    @(negedge CLK); RESETN = 1'b1;
    #1 check("rst_ready", 32'(c0_ready), 32'd1);
    repeat (2) @(negedge CLK);

    // single write: target 2, data 3
    w.en = 4'b0100; w.data = 2'd3;
    exp_wr.push_back(w); exp_done.push_back(2);
    send0(2'd2, 2'd3, acc);
    edges(1);
    check("single_en", 32'(c0_en), 32'h4);
    check("single_data", 32'(c0_cfg_data), 32'd3);
    check("single_done_early", 32'(c0_done), 32'd0);
    edges(1);
    check("single_en_off", 32'(c0_en), 32'd0);
`ifdef CFG_VERIFY_EN
    check("single_done_e2", 32'(c0_done), 32'd0);
    edges(1);
    check("single_done_e3", 32'(c0_done), 32'd1);
`else
    check("single_done_e2", 32'(c0_done), 32'd1);
`endif
    check("single_err", 32'(c0_err), 32'd0);
    wait_idle(20); edges(2);

    // readback of target 1 forced to 0, write data 2
    rb_kill = 4'b0010;
    w.en = 4'b0010; w.data = 2'd2;
    exp_wr.push_back(w);
`ifdef CFG_VERIFY_EN
    exp_err.push_back(1);
    send0(2'd1, 2'd2, acc);
    edges(3);
    check("mm_err", 32'(c0_err), 32'd1);
    check("mm_err_target", 32'(c0_errt), 32'd1);
    check("mm_no_done", 32'(c0_done), 32'd0);
    @(negedge CLK); c0_errclr = 1'b1;
    @(posedge CLK); #1 c0_errclr = 1'b0;
    check("mm_err_cleared", 32'(c0_err), 32'd0);
`else
    exp_done.push_back(1);
    send0(2'd1, 2'd2, acc);
    edges(2);
    check("mm_done_anyway", 32'(c0_done), 32'd1);
    edges(1);
    check("mm_no_err", 32'(c0_err), 32'd0);
`endif
    rb_kill = 4'b0;
    wait_idle(20); edges(2);

    // FIFO fill: back-to-back commands, backpressure timing
    for (int i = 0; i < 8; i++) begin
      w.en = 4'b0001 << fill_tgt[i]; w.data = fill_data[i];
      exp_wr.push_back(w); exp_done.push_back(int'(fill_tgt[i]));
    end
    for (int i = 0; i < 8; i++) begin
      send0(fill_tgt[i], fill_data[i], acc);
      accs[i] = acc;
    end
    for (int i = 1; i < 8; i++)
      check($sformatf("fill_accept_%0d", i), 32'(accs[i] - accs[0]), 32'(fill_off[i]));
    wait_idle(100); edges(3);

    // out-of-range target on the 3-target instance
    send1(2'd3, 2'd1);
    saw_en = 1'b0; saw_done = 1'b0;
    repeat (5) begin
      edges(1);
      if (c1_en != 3'b0) saw_en = 1'b1;
      if (c1_done) saw_done = 1'b1;
    end
    check("oor_no_en", 32'(saw_en), 32'd0);
    check("oor_no_done", 32'(saw_done), 32'd0);
    check("oor_err", 32'(c1_err), 32'd1);
    check("oor_err_target", 32'(c1_errt), 32'd3);
    send1(2'd0, 2'd2);
    en_seen = 3'b0; saw_done = 1'b0;
    repeat (6) begin
      edges(1);
      en_seen = en_seen | c1_en;
      if (c1_done) saw_done = 1'b1;
    end
    check("oor_next_en", 32'(en_seen), 32'h1);
    check("oor_next_done", 32'(saw_done), 32'd1);
    check("oor_next_q", 32'(q1[0]), 32'd2);

    // async reset during WRITE with a second command queued
    send0(2'd0, 2'd1, acc);
    send0(2'd3, 2'd2, acc);
    check("ar_en_before", 32'(c0_en), 32'h1);
    #1 RESETN = 1'b0;
    #1;
    check("ar_en_killed", 32'(c0_en), 32'd0);
    check("ar_data_killed", 32'(c0_cfg_data), 32'd0);
    check("ar_busy", 32'(c0_busy), 32'd0);
    check("ar_err", 32'(c0_err), 32'd0);
    @(negedge CLK); RESETN = 1'b1;
    edges(2);
    check("ar_fifo_flushed", 32'(c0_busy), 32'd0);
    w.en = 4'b1000; w.data = 2'd2;
    exp_wr.push_back(w); exp_done.push_back(3);
    send0(2'd3, 2'd2, acc);
    wait_done(10);
    wait_idle(20); edges(4);

    check("left_writes", 32'(exp_wr.size()), 32'd0);
    check("left_dones", 32'(exp_done.size()), 32'd0);
    check("left_errs", 32'(exp_err.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
